debounce_pulse: RTL and testbench

//  Conditions a raw, bouncing, asynchronous push-button into a clean debounced

---
 rtl/debounce_pulse_pkg.sv | 17 +
 rtl/debounce_pulse_sync_chain.sv | 25 ++
 rtl/debounce_pulse.sv | 151 +++++++++++++++
 tb/tb_debounce_pulse.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pulse_pkg.sv
// Shared definitions for the push-button debounce slice: FSM state
// encoding and default timing constants.
package debounce_pulse_pkg;

    // Bit 1 of the encoding equals the debounced level in that state.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } db_state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 1000000;
    localparam int DEF_CNT_WIDTH     = 20;

endpackage

// File: rtl/debounce_pulse_sync_chain.sv
// N-flop synchroniser for an asynchronous single-bit input.
// Resets to 0; the last stage is the only output.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_r;

    // Shift the raw input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_r <= {STAGES{1'b0}};
        end else begin
            ff_r <= {ff_r[STAGES-2:0], d};
        end
    end

    assign q = ff_r[STAGES-1];

endmodule

// File: rtl/debounce_pulse.sv
// Push-button conditioner: synchronises btn_in, requires STABLE_CYCLES
// consecutive enabled samples of a new value before accepting it, and
// emits registered level plus single-cycle rise/fall strobes.
module debounce_pulse
    import debounce_pulse_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic smp_en,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 btn_sync_s;
    db_state_t            state_r;
    db_state_t            state_next_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_next_s;
    logic                 at_last_s;
    logic                 level_next_s;
    logic                 rise_next_s;
    logic                 fall_next_s;
    logic                 level_r;
    logic                 rise_r;
    logic                 fall_r;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync_s)
    );

    assign at_last_s = (cnt_r == CNT_LAST);

    // FSM state and stability counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE_LOW;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next state / counter: advance only on enabled samples; a bounce or
    // an accept clears the counter, so it never wraps.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        if (smp_en) begin
            case (state_r)
                IDLE_LOW: begin
                    if (btn_sync_s) begin
                        state_next_s = WAIT_HIGH;
                        cnt_next_s   = CNT_ONE;
                    end else begin
                        state_next_s = IDLE_LOW;
                        cnt_next_s   = CNT_ZERO;
                    end
                end
                WAIT_HIGH: begin
                    if (!btn_sync_s) begin
                        state_next_s = IDLE_LOW;
                        cnt_next_s   = CNT_ZERO;
                    end else if (at_last_s) begin
                        state_next_s = IDLE_HIGH;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        state_next_s = WAIT_HIGH;
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!btn_sync_s) begin
                        state_next_s = WAIT_LOW;
                        cnt_next_s   = CNT_ONE;
                    end else begin
                        state_next_s = IDLE_HIGH;
                        cnt_next_s   = CNT_ZERO;
                    end
                end
                WAIT_LOW: begin
                    if (btn_sync_s) begin
                        state_next_s = IDLE_HIGH;
                        cnt_next_s   = CNT_ZERO;
                    end else if (at_last_s) begin
                        state_next_s = IDLE_LOW;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        state_next_s = WAIT_LOW;
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_next_s = IDLE_LOW;
                    cnt_next_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_next_s = state_r;
            cnt_next_s   = cnt_r;
        end
    end

    // Output decode: strobes fire only on the accepting transition.
    always_comb begin
        rise_next_s  = smp_en && (state_r == WAIT_HIGH) && btn_sync_s && at_last_s;
        fall_next_s  = smp_en && (state_r == WAIT_LOW) && !btn_sync_s && at_last_s;
        level_next_s = level_r;
        if (rise_next_s) begin
            level_next_s = 1'b1;
        end else if (fall_next_s) begin
            level_next_s = 1'b0;
        end else begin
            level_next_s = level_r;
        end
    end

    // Registered outputs; strobes self-clear because the FSM has left the
    // WAIT state by the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            level_r <= level_next_s;
            rise_r  <= rise_next_s;
            fall_r  <= fall_next_s;
        end
    end

    assign btn_level = level_r;
    assign btn_rise  = rise_r;
    assign btn_fall  = fall_r;

endmodule

// File: tb/tb_debounce_pulse.sv
// Self-checking bench for debounce_pulse (SYNC_STAGES = 2, STABLE_CYCLES = 4).
// Reference model: input delayed by the synchroniser depth, then a run
// length of consecutive enabled samples differing from the accepted level.
module tb_debounce_pulse;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int CW     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_in = 1'b0;
    logic smp_en = 1'b1;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [SYNC-1:0] m_hist = '0;
    int   m_run   = 0;
    logic m_level = 1'b0;
    logic m_rise  = 1'b0;
    logic m_fall  = 1'b0;

    // observation counters
    int       rise_seen = 0;
    int       fall_seen = 0;
    logic [3:0] q = 4'd0;

    debounce_pulse #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .smp_en    (smp_en),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge, using the inputs present at it.
    task automatic model_step(input logic b, input logic e, input logic r);
        logic s;
        if (r) begin
            m_hist  = '0;
            m_run   = 0;
            m_level = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
        end else begin
            s      = m_hist[SYNC-1];
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (e) begin
                if (s != m_level) begin
                    m_run = m_run + 1;
                    if (m_run == STABLE) begin
                        m_level = s;
                        m_rise  = s;
                        m_fall  = !s;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_hist = {m_hist[SYNC-2:0], b};
        end
    endtask

    task automatic tick(input logic b, input logic e);
        btn_in = b;
        smp_en = e;
        @(posedge clk);
        model_step(b, e, rst);
        #1;
        chk("level", btn_level, m_level);
        chk("rise", btn_rise, m_rise);
        chk("fall", btn_fall, m_fall);
        chk("strobe_excl", btn_rise & btn_fall, 1'b0);
        if (btn_rise === 1'b1) begin
            q = q + 4'd1;
            rise_seen++;
        end
        if (btn_fall === 1'b1) begin
            fall_seen++;
        end
    endtask

    // Hold btn at b with smp_en=1 and count edges until btn_level == target.
    task automatic measure(input logic b, input logic target, input string tag, input int exp_edges);
        int edges;
        edges = 0;
        for (int i = 0; i < 64; i++) begin
            tick(b, 1'b1);
            edges++;
            if (btn_level === target) break;
        end
        chk(tag, edges, exp_edges);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        chk("rst_level", btn_level, 1'b0);
        chk("rst_rise", btn_rise, 1'b0);
        chk("rst_fall", btn_fall, 1'b0);
        for (int i = 0; i < n; i++) tick(btn_in, smp_en);
        rst = 1'b0;
    endtask

    task automatic bouncy_press();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1); tick(1'b1, 1'b1);
            tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        end
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1); tick(1'b0, 1'b1);
            tick(1'b1, 1'b1); tick(1'b1, 1'b1);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
    endtask

    initial begin
        int rs;
        int fs;
        logic v;
        int len;

        // 1. reset held with button pressed, then full latency
        btn_in = 1'b1;
        rst = 1'b1;
        #1;
        @(negedge clk);
        do_reset(3);
        rs = rise_seen;
        measure(1'b1, 1'b1, "t1_latency", 6);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        chk("t1_rise_count", rise_seen - rs, 1);

        // 2. clean release and press
        fs = fall_seen;
        measure(1'b0, 1'b0, "t2_release_latency", 6);
        chk("t2_fall_count", fall_seen - fs, 1);
        rs = rise_seen;
        measure(1'b1, 1'b1, "t2_press_latency", 6);
        for (int i = 0; i < 14; i++) tick(1'b1, 1'b1);
        chk("t2_rise_count", rise_seen - rs, 1);
        measure(1'b0, 1'b0, "t2_release2_latency", 6);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);

        // 3. bounce every 2 clk for 12 clk, then steady 1
        rs = rise_seen;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1); tick(1'b1, 1'b1);
            tick(1'b0, 1'b1); tick(1'b0, 1'b1);
            chk("t3_level_bounce", btn_level, 1'b0);
        end
        measure(1'b1, 1'b1, "t3_latency", 6);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);
        chk("t3_rise_count", rise_seen - rs, 1);

        // 4. smp_en one clk in four
        measure(1'b0, 1'b0, "t4_pre_release", 6);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
        len = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, (k % 4) == 0);
            len++;
            if (btn_level === 1'b1) break;
        end
        chk("t4_slow_latency", len, 17);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
        chk("t4_frozen_level", btn_level, 1'b1);
        measure(1'b0, 1'b0, "t4_resume_latency", 2);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);

        // 5. reset pulsed while waiting with cnt = 2
        rs = rise_seen;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        do_reset(2);
        chk("t5_no_strobe", rise_seen - rs, 0);
        chk("t5_level", btn_level, 1'b0);
        measure(1'b1, 1'b1, "t5_latency", 6);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        measure(1'b0, 1'b0, "t5_release", 6);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);

        // 6. integration with a 4-bit counter on btn_rise
        q = 4'd0;
        for (int p = 0; p < 3; p++) bouncy_press();
        chk("t6_q3", q, 4'd3);
        for (int p = 0; p < 14; p++) bouncy_press();
        chk("t6_q17", q, 4'd1);

        // randomized segments with random smp_en and occasional reset
        for (int seg = 0; seg < 300; seg++) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) tick(v, $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
